// File: rtl/tt_um_leg_solver.sv
// Iterative Pythagorean leg solver: B = floor(sqrt(C*C - A*A)) using a strobed byte
// operand interface and an 8-cycle restoring bit-serial square-root engine.
module tt_um_leg_solver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROOT,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  c_reg, a_reg;
  logic [7:0]  root, result;
  logic [15:0] rad;
  logic [9:0]  rem;
  logic [2:0]  cnt;
  logic        start_q;
  logic        err;

  logic        load_c, load_a, load_any, start_evt, a_gt_c;
  logic        load_ok, start_ok, finish;
  logic [15:0] c_sq, a_sq;
  logic [11:0] rem_sh, trial, rem_diff;
  logic        rem_ge;
  logic [9:0]  rem_nxt;
  logic [7:0]  root_nxt;
  logic        unused;

  assign unused    = &{ena, uio_in[7:3], 1'b0};
  assign load_c    = uio_in[0];
  assign load_a    = uio_in[1];
  assign load_any  = load_c | load_a;
  assign start_evt = uio_in[2] & ~start_q;
  assign a_gt_c    = a_reg > c_reg;
  assign c_sq      = {8'd0, c_reg} * {8'd0, c_reg};
  assign a_sq      = {8'd0, a_reg} * {8'd0, a_reg};

  // One restoring step: bring down the next two radicand bits and try root*4+1.
  always_comb begin
    rem_sh   = {rem, rad[15:14]};
    trial    = {2'b00, root, 2'b01};
    rem_ge   = rem_sh >= trial;
    rem_diff = rem_sh - trial;
    rem_nxt  = rem_ge ? rem_diff[9:0] : rem_sh[9:0];
    root_nxt = {root[6:0], rem_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_ok   = 1'b0;
    start_ok  = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (load_any) begin
          load_ok   = 1'b1;
          state_nxt = S_IDLE;
        end else if (start_evt) begin
          start_ok  = 1'b1;
          state_nxt = a_gt_c ? S_DONE : S_ROOT;
        end
      end
      S_ROOT: begin
        if (cnt == 3'd0) begin
          finish    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_reg   <= '0;
      a_reg   <= '0;
      rad     <= '0;
      rem     <= '0;
      root    <= '0;
      cnt     <= '0;
      result  <= '0;
      err     <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= uio_in[2];
      if (load_ok) begin
        if (load_c) c_reg <= ui_in;
        if (load_a) a_reg <= ui_in;
        err <= 1'b0;
      end
      if (start_ok) begin
        if (a_gt_c) begin
          err    <= 1'b1;
          result <= '0;
        end else begin
          rad  <= c_sq - a_sq;
          rem  <= '0;
          root <= '0;
          cnt  <= 3'd7;
          err  <= 1'b0;
        end
      end
      if (state == S_ROOT) begin
        rad  <= {rad[13:0], 2'b00};
        rem  <= rem_nxt;
        root <= root_nxt;
        cnt  <= cnt - 3'd1;
        if (finish) result <= root_nxt;
      end
    end
  end

  assign uo_out  = result;
  assign uio_out = {state == S_DONE, state == S_ROOT, err, 5'b00000};
  assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_leg_solver.sv
// Self-checking bench for tt_um_leg_solver: directed vector table, multi-cycle
// corner sequences and randomized operands against an integer-sqrt reference.
module tb_tt_um_leg_solver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;
  int last_b = 0;

  typedef struct {
    int c;
    int a;
    int b;
    int e;
  } vec_t;

  vec_t tbl[6];

  tt_um_leg_solver dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: largest b with b*b <= c*c - a*a, or error when a > c.
  function automatic int ref_leg(input int c, input int a);
    int r, b;
    if (a > c) return 0;
    r = c * c - a * a;
    b = 0;
    while ((b + 1) * (b + 1) <= r) b++;
    return b;
  endfunction

  task automatic load_ops(input int c, input int a);
    uio_in = 8'h01; ui_in = c[7:0]; step();
    uio_in = 8'h02; ui_in = a[7:0]; step();
    uio_in = 8'h00;
  endtask

  // Full transaction with cycle-exact status checks; status = {done,busy,err}.
  task automatic do_op(input string nm, input int c, input int a, input int b, input int e);
    load_ops(c, a);
    uio_in = 8'h04; step();
    uio_in = 8'h00;
    if (e != 0) begin
      chk({nm, "_err_edge"}, {uio_out, uo_out}, {8'b1010_0000, 8'd0});
      step();
      chk({nm, "_err_hold"}, {uio_out, uo_out}, {8'b1010_0000, 8'd0});
      last_b = 0;
    end else begin
      chk({nm, "_busy_k"}, {uio_out, uo_out}, {8'b0100_0000, last_b[7:0]});
      for (int i = 1; i < 8; i++) begin
        step();
        chk({nm, "_busy_run"}, {uio_out, uo_out}, {8'b0100_0000, last_b[7:0]});
      end
      step();
      chk({nm, "_done"}, {uio_out, uo_out}, {8'b1000_0000, b[7:0]});
      last_b = b;
    end
  endtask

  initial begin
    int busy_cnt, c, a, e;

    tbl[0] = '{c: 5,   a: 3,   b: 4,   e: 0};
    tbl[1] = '{c: 255, a: 0,   b: 255, e: 0};
    tbl[2] = '{c: 200, a: 100, b: 173, e: 0};
    tbl[3] = '{c: 13,  a: 5,   b: 12,  e: 0};
    tbl[4] = '{c: 10,  a: 10,  b: 0,   e: 0};
    tbl[5] = '{c: 3,   a: 5,   b: 0,   e: 1};

    #12;
    chk("reset_outputs", {uo_out, uio_out, uio_oe}, {8'd0, 8'd0, 8'hE0});
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", {uo_out, uio_out}, {8'd0, 8'd0});

    foreach (tbl[i]) begin
      do_op($sformatf("vec%0d", i), tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].e);
      chk("vec_model_agrees", ref_leg(tbl[i].c, tbl[i].a), tbl[i].b);
    end

    // Held START triggers exactly one computation.
    load_ops(13, 5);
    uio_in = 8'h04;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (uio_out[6]) busy_cnt++;
    end
    uio_in = 8'h00;
    chk("held_start_busy_cycles", busy_cnt, 8);
    chk("held_start_result", {uio_out, uo_out}, {8'b1000_0000, 8'd12});
    step();
    chk("held_start_no_retrigger", uio_out, 8'b1000_0000);
    last_b = 12;

    // Operand loads during ROOT are ignored.
    load_ops(5, 3);
    uio_in = 8'h04; step();
    uio_in = 8'h02; ui_in = 8'd7;
    step(); step(); step();
    uio_in = 8'h00;
    for (int i = 0; i < 5; i++) step();
    chk("load_in_root_ignored", {uio_out, uo_out}, {8'b1000_0000, 8'd4});
    // Restart from DONE with no load: A must still be 3; uo_out holds until k+8.
    uio_in = 8'h04; step();
    uio_in = 8'h00;
    chk("restart_done_falls", {uio_out, uo_out}, {8'b0100_0000, 8'd4});
    for (int i = 0; i < 8; i++) step();
    chk("restart_result", {uio_out, uo_out}, {8'b1000_0000, 8'd4});
    uio_in = 8'h02; ui_in = 8'd7; step();
    uio_in = 8'h00;
    chk("load_in_done_clears", {uio_out, uo_out}, {8'b0000_0000, 8'd4});
    // A=7 > C=5 now: error path from IDLE.
    uio_in = 8'h04; step();
    uio_in = 8'h00;
    chk("err_after_reload", {uio_out, uo_out}, {8'b1010_0000, 8'd0});
    last_b = 0;

    // Load and start in the same cycle: load wins, start dropped.
    uio_in = 8'h05; ui_in = 8'd9; step();
    uio_in = 8'h00;
    chk("load_beats_start", uio_out, 8'b0000_0000);
    step();
    chk("load_beats_start_idle", uio_out, 8'b0000_0000);

    // Asynchronous reset in the middle of ROOT.
    load_ops(200, 100);
    uio_in = 8'h04; step();
    uio_in = 8'h00;
    for (int i = 0; i < 4; i++) step();
    chk("mid_root_busy", uio_out, 8'b0100_0000);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {uo_out, uio_out, uio_oe}, {8'd0, 8'd0, 8'hE0});
    #2 rst_n = 1'b1;
    step();
    chk("post_reset_idle", {uo_out, uio_out}, {8'd0, 8'd0});
    last_b = 0;
    do_op("post_reset_run", 5, 4, 3, 0);

    // Randomized operands against the reference model.
    for (int n = 0; n < 40; n++) begin
      c = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 255);
      else                           a = $urandom_range(0, c);
      e = (a > c) ? 1 : 0;
      do_op($sformatf("rand%0d_c%0d_a%0d", n, c, a), c, a, ref_leg(c, a), e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
